// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register (hold / shift left / shift right /
// parallel load) with a saturating count of shifts since the last load.
// Optional feature macro: UNIV_SHREG_ROTATE_EN adds input 'rot', which turns
// both shift modes into rotates (serial inputs ignored, counting unchanged).
module univ_shift_reg #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter int unsigned           CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             sin_l,
    input  logic             sin_r,
`ifdef UNIV_SHREG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             fill_l;
    logic             fill_r;
    logic             cnt_sat;

    assign cnt_sat = (shift_cnt == CNT_FULL);

    // Select the bits entering each end on a shift: serial inputs, or the
    // opposite end of q when rotating.
    always_comb begin
        fill_l = sin_l;
        fill_r = sin_r;
`ifdef UNIV_SHREG_ROTATE_EN
        if (rot) begin
            fill_l = q[WIDTH-1];
            fill_r = q[0];
        end
`endif
    end

    // Next-state for register contents and shift counter (enable gating and
    // mode decode; reset is applied in the register process).
    always_comb begin
        q_nxt   = q;
        cnt_nxt = shift_cnt;
        if (en) begin
            unique case (mode_t'(mode))
                MODE_HOLD: begin
                    q_nxt   = q;
                    cnt_nxt = shift_cnt;
                end
                MODE_SHL: begin
                    q_nxt   = {q[WIDTH-2:0], fill_l};
                    cnt_nxt = cnt_sat ? shift_cnt : shift_cnt + 1'b1;
                end
                MODE_SHR: begin
                    q_nxt   = {fill_r, q[WIDTH-1:1]};
                    cnt_nxt = cnt_sat ? shift_cnt : shift_cnt + 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt   = data;
                    cnt_nxt = '0;
                end
                default: begin
                    q_nxt   = q;
                    cnt_nxt = shift_cnt;
                end
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= RESET_VALUE;
            shift_cnt <= CNT_FULL;
        end else begin
            q         <= q_nxt;
            shift_cnt <= cnt_nxt;
        end
    end

    assign sout_l  = q[WIDTH-1];
    assign sout_r  = q[0];
    assign drained = cnt_sat;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed test of univ_shift_reg with WIDTH=8,
// RESET_VALUE=8'hA5. Define UNIV_SHREG_ROTATE_EN to also cover rotate mode.
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
    logic             sin_l;
    logic             sin_r;
`ifdef UNIV_SHREG_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CNT_W-1:0] shift_cnt;
    logic             drained;

    int unsigned n_cmp;
    int unsigned n_err;

    univ_shift_reg #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .data     (data),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
`ifdef UNIV_SHREG_ROTATE_EN
        .rot      (rot),
`endif
        .q        (q),
        .sout_l   (sout_l),
        .sout_r   (sout_r),
        .shift_cnt(shift_cnt),
        .drained  (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        en   = 1'b1;
        mode = 2'b11;
        data = v;
        step();
    endtask

    logic [7:0] exp_sout_r;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        en     = 1'b0;
        mode   = 2'b00;
        data   = '0;
        sin_l  = 1'b0;
        sin_r  = 1'b0;
`ifdef UNIV_SHREG_ROTATE_EN
        rot    = 1'b0;
`endif
        @(negedge clk);

        // 1. Reset overrides en=0 and mode=11
        reset = 1'b1;
        en    = 1'b0;
        mode  = 2'b11;
        data  = 8'h3C;
        step();
        reset = 1'b0;
        check("rst_q",       32'(q),         32'hA5);
        check("rst_cnt",     32'(shift_cnt), 32'd8);
        check("rst_drained", 32'(drained),   32'd1);
        check("rst_sout_l",  32'(sout_l),    32'd1);
        check("rst_sout_r",  32'(sout_r),    32'd1);

        // 2. Load C3 and serialise out of bit 0
        load(8'hC3);
        check("ld_q",       32'(q),         32'hC3);
        check("ld_cnt",     32'(shift_cnt), 32'd0);
        check("ld_drained", 32'(drained),   32'd0);
        exp_sout_r = 8'b1100_0011;
        mode  = 2'b10;
        sin_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ser_sout_r%0d", i), 32'(sout_r), 32'(exp_sout_r[i]));
            step();
            check($sformatf("ser_cnt%0d", i), 32'(shift_cnt), 32'(i + 1));
            check($sformatf("ser_drained%0d", i), 32'(drained), (i == 7) ? 32'd1 : 32'd0);
        end
        check("ser_q", 32'(q), 32'h00);
        step();
        check("ser9_cnt",     32'(shift_cnt), 32'd8);
        check("ser9_drained", 32'(drained),   32'd1);

        // 3. Shift-left fill with ones
        load(8'h00);
        mode  = 2'b01;
        sin_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("shl_sout_l%0d", i), 32'(sout_l), 32'd0);
            step();
        end
        check("shl_q",       32'(q),         32'h07);
        check("shl_cnt",     32'(shift_cnt), 32'd3);
        check("shl_drained", 32'(drained),   32'd0);
        check("shl_sout_l",  32'(sout_l),    32'd0);

        // 4. Enable gating and hold mode
        load(8'h5A);
        en   = 1'b0;
        mode = 2'b01;
        for (int i = 0; i < 4; i++) step();
        check("en0_q",   32'(q),         32'h5A);
        check("en0_cnt", 32'(shift_cnt), 32'd0);
        en   = 1'b1;
        mode = 2'b00;
        step();
        step();
        check("hold_q",   32'(q),         32'h5A);
        check("hold_cnt", 32'(shift_cnt), 32'd0);

        // 5. Reset in the middle of a shift sequence
        load(8'hFF);
        mode  = 2'b10;
        sin_r = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("mid_q",   32'(q),         32'h1F);
        check("mid_cnt", 32'(shift_cnt), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_q",   32'(q),         32'hA5);
        check("midrst_cnt", 32'(shift_cnt), 32'd8);

        // Direction change mid-sequence: each shift counts once
        load(8'h81);
        mode  = 2'b01;
        sin_l = 1'b0;
        step();
        check("dir_shl_q", 32'(q), 32'h02);
        mode  = 2'b10;
        sin_r = 1'b1;
        step();
        check("dir_shr_q", 32'(q),         32'h81);
        check("dir_cnt",   32'(shift_cnt), 32'd2);

`ifdef UNIV_SHREG_ROTATE_EN
        // 6. Rotate ignores serial inputs, still counts
        load(8'h81);
        rot   = 1'b1;
        sin_l = 1'b0;
        sin_r = 1'b0;
        mode  = 2'b01;
        step();
        check("rot_l_q", 32'(q), 32'h03);
        mode = 2'b10;
        step();
        step();
        check("rot_r_q",   32'(q),         32'hC0);
        check("rot_cnt",   32'(shift_cnt), 32'd3);
        mode = 2'b11;
        data = 8'h12;
        step();
        check("rot_load_q", 32'(q), 32'h12);
        rot = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
